fifo_rd_stream: RTL

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

---
 rtl/fifo_rd_stream_pkg.sv | 21 ++
 rtl/fifo_rd_skid_buf.sv | 62 ++++++
 rtl/fifo_rd_stream.sv | 83 ++++++++
 3 files changed

// File: rtl/fifo_rd_stream_pkg.sv
// fifo_rd_stream_pkg
// Constants shared by the FIFO read-side streaming adapter and its skid buffer.
//   RD_LATENCY_MAX : largest supported FIFO read latency (cycles)
//   DEPTH_MAX      : largest skid buffer depth (RD_LATENCY_MAX + 1)
//   LEVEL_W        : width of occupancy / in-flight counters (holds 0..DEPTH_MAX)
//   PTR_W          : width of the skid buffer read/write pointers
//   OCC_W          : width of level + in-flight sums used by the read-issue check
package fifo_rd_stream_pkg;

    localparam int RD_LATENCY_MAX = 2;
    localparam int DEPTH_MAX      = RD_LATENCY_MAX + 1;
    localparam int LEVEL_W        = $clog2(DEPTH_MAX + 1);
    localparam int PTR_W          = $clog2(DEPTH_MAX);
    localparam int OCC_W          = LEVEL_W + 1;

    // One slot per word that can be in flight plus one for the word on the output.
    function automatic int skid_depth(input int rd_latency);
        return rd_latency + 1;
    endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// fifo_rd_skid_buf
// Small circular buffer absorbing words that land from the FIFO after the
// downstream stalls.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset; clears pointers, level and storage
//   clr     : synchronous discard of all stored words (storage left as is)
//   wr_en   : write wr_data at the tail
//   wr_data : landing word
//   rd_en   : remove the head word
//   rd_data : head word (register output)
//   level   : number of stored words, 0..DEPTH
module fifo_rd_skid_buf
    import fifo_rd_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [LEVEL_W-1:0]    level
);

    logic [DATA_WIDTH-1:0] mem [DEPTH_MAX];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH_MAX; i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (rd_en) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            level <= level + LEVEL_W'(wr_en) - LEVEL_W'(rd_en);
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
// Turns a fixed-latency FIFO read port into a valid/ready stream. Reads are
// only issued when every word already committed (buffered or in flight) is
// guaranteed a skid buffer slot, so the downstream can stall at any time.
//   rd_clk        : clock, rising edge
//   rd_rst        : synchronous active-high reset (wins over flush)
//   flush         : discard buffered and in-flight words
//   fifo_rd_empty : FIFO empty flag
//   fifo_rd_data  : FIFO read data, valid RD_LATENCY cycles after fifo_rd_en
//   fifo_rd_en    : FIFO pop (combinational)
//   m_valid       : stream word available
//   m_ready       : downstream accepts word
//   m_data        : stream word (registered)
//   m_level       : skid buffer occupancy
// RD_LATENCY must be 1 or 2.
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  flush,
    input  logic                  fifo_rd_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [LEVEL_W-1:0]    m_level
);

    localparam int DEPTH = skid_depth(RD_LATENCY);

    logic               pop;
    logic               land;
    logic               vld_p1;
    logic               vld_p2;
    logic [LEVEL_W-1:0] inflight;
    logic [OCC_W-1:0]   occ;

    assign m_valid = (m_level != '0);
    assign pop     = m_valid && m_ready;

    // Slots still claimed after this cycle; a landing word is counted in
    // inflight until its edge, so it never gets counted twice.
    assign occ = OCC_W'(m_level) + OCC_W'(inflight) - OCC_W'(pop);

    assign fifo_rd_en = !rd_rst && !flush && !fifo_rd_empty && (occ < OCC_W'(DEPTH));

    // Read issue -> p1 -> p2: vld_pN marks that fifo_rd_data carries a word
    // requested N cycles ago. Clearing these on flush drops pre-flush reads.
    always_ff @(posedge rd_clk) begin
        if (rd_rst || flush) begin
            vld_p1   <= 1'b0;
            vld_p2   <= 1'b0;
            inflight <= '0;
        end else begin
            vld_p1   <= fifo_rd_en;
            vld_p2   <= (RD_LATENCY == 2) ? vld_p1 : 1'b0;
            inflight <= inflight + LEVEL_W'(fifo_rd_en) - LEVEL_W'(land);
        end
    end

    assign land = (RD_LATENCY == 1) ? vld_p1 : vld_p2;

    // Landing stage: word captured into the skid buffer tail.
    fifo_rd_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_skid (
        .clk     (rd_clk),
        .rst     (rd_rst),
        .clr     (flush),
        .wr_en   (land),
        .wr_data (fifo_rd_data),
        .rd_en   (pop),
        .rd_data (m_data),
        .level   (m_level)
    );

endmodule
